// File: rtl/center_of_mass_if.sv
// Pixel-stream interface for the centroid block: mask pixel coordinates and
// end-of-frame strobe in, centroid result and update pulse out.
interface center_of_mass_if;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic        valid_in;
  logic        tabulate_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        valid_out;

  modport master (
    output x_in, y_in, valid_in, tabulate_in,
    input  x_out, y_out, valid_out
  );

  modport slave (
    input  x_in, y_in, valid_in, tabulate_in,
    output x_out, y_out, valid_out
  );
endinterface

// File: rtl/center_of_mass.sv
// Per-frame centroid of mask pixels: accumulate sums and count during the frame,
// then run two restoring dividers (one quotient bit per cycle) and publish floor means.
module center_of_mass #(
  parameter int unsigned H_ACTIVE  = 1280,
  parameter int unsigned V_ACTIVE  = 720,
  parameter int unsigned MIN_COUNT = 16
) (
  input logic             clk_in,
  input logic             rst_in_n,
  center_of_mass_if.slave bus
);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    DIVIDE  = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  // Divider state: the dividend sits in quo and shifts out MSB-first as quotient bits shift in.
  typedef struct packed {
    logic [19:0] rem;
    logic [31:0] quo;
  } div_t;

  function automatic div_t div_step(input div_t cur, input logic [19:0] divisor);
    logic [20:0] trial;
    div_t        nxt;
    trial   = {cur.rem, cur.quo[31]};
    nxt.quo = {cur.quo[30:0], 1'b0};
    if (trial >= {1'b0, divisor}) begin
      trial      = trial - {1'b0, divisor};
      nxt.quo[0] = 1'b1;
    end
    nxt.rem = trial[19:0];
    return nxt;
  endfunction

  state_t      r_state, w_state_next;
  logic [30:0] r_sum_x;
  logic [29:0] r_sum_y;
  logic [19:0] r_count;
  div_t        r_div_x, r_div_y;
  logic [19:0] r_divisor;
  logic [4:0]  r_iter;
  logic [10:0] r_x_out;
  logic [9:0]  r_y_out;
  logic        r_valid_out;

  logic w_pix_ok;
  logic w_start;

  assign w_pix_ok = bus.valid_in
                 && ({21'b0, bus.x_in} < H_ACTIVE)
                 && ({22'b0, bus.y_in} < V_ACTIVE);
  assign w_start  = (r_state == ACCUM) && bus.tabulate_in && ({12'b0, r_count} >= MIN_COUNT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) r_state <= ACCUM;
    else           r_state <= w_state_next;
  end

  // NOTE: next state defaults to the current state first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCUM:   if (w_start) w_state_next = DIVIDE;
      DIVIDE:  if (r_iter == 5'd31) w_state_next = PUBLISH;
      PUBLISH: w_state_next = ACCUM;
      default: w_state_next = ACCUM;
    endcase
  end

  // A tabulate strobe in any state closes the frame; a pixel on that cycle seeds the next one.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_count <= '0;
    end else if (bus.tabulate_in) begin
      r_sum_x <= w_pix_ok ? {20'b0, bus.x_in} : '0;
      r_sum_y <= w_pix_ok ? {20'b0, bus.y_in} : '0;
      r_count <= {19'b0, w_pix_ok};
    end else if (w_pix_ok) begin
      r_sum_x <= r_sum_x + {20'b0, bus.x_in};
      r_sum_y <= r_sum_y + {20'b0, bus.y_in};
      r_count <= r_count + 20'd1;
    end
  end

  // NOTE: divider registers are reset too, so an aborted divide leaves no stale quotient behind.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_div_x   <= '0;
      r_div_y   <= '0;
      r_divisor <= '0;
      r_iter    <= '0;
    end else if (w_start) begin
      r_div_x   <= '{rem: 20'b0, quo: {1'b0, r_sum_x}};
      r_div_y   <= '{rem: 20'b0, quo: {2'b0, r_sum_y}};
      r_divisor <= r_count;
      r_iter    <= '0;
    end else if (r_state == DIVIDE) begin
      r_div_x   <= div_step(r_div_x, r_divisor);
      r_div_y   <= div_step(r_div_y, r_divisor);
      r_iter    <= r_iter + 5'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_x_out     <= '0;
      r_y_out     <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= (r_state == PUBLISH);
      if (r_state == PUBLISH) begin
        r_x_out <= r_div_x.quo[10:0];
        r_y_out <= r_div_y.quo[9:0];
      end
    end
  end

  assign bus.x_out     = r_x_out;
  assign bus.y_out     = r_y_out;
  assign bus.valid_out = r_valid_out;

endmodule

// File: tb/tb_center_of_mass.sv
// Scoreboard bench for center_of_mass: a behavioural frame model pushes expected
// centroids and publish cycles; a negedge monitor pops and compares each pulse.
module tb_center_of_mass;
  localparam int H_ACTIVE  = 1280;
  localparam int V_ACTIVE  = 720;
  localparam int MIN_COUNT = 16;
  localparam int LAT       = 33;

  logic clk_in   = 1'b0;
  logic rst_in_n = 1'b0;

  center_of_mass_if bus();

  center_of_mass #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .MIN_COUNT(MIN_COUNT)
  ) dut (
    .clk_in  (clk_in),
    .rst_in_n(rst_in_n),
    .bus     (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int     x;
    int     y;
    longint cyc;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  longint m_sx = 0, m_sy = 0, m_cnt = 0;
  longint busy_end = -1;
  int     last_x = 0, last_y = 0;
  logic   prev_valid = 1'b0;
  exp_t   got_e;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one pixel cycle (called just after a negedge) and update the frame model.
  task automatic drive(input int x, input int y, input bit v, input bit tab);
    bit ok;
    bus.x_in        = 11'(x);
    bus.y_in        = 10'(y);
    bus.valid_in    = v;
    bus.tabulate_in = tab;
    ok = v && (x < H_ACTIVE) && (y < V_ACTIVE);
    if (tab) begin
      if ((cyc + 1 > busy_end) && (m_cnt >= MIN_COUNT)) begin
        sb.push_back('{int'(m_sx / m_cnt), int'(m_sy / m_cnt), cyc + 1 + LAT});
        busy_end = cyc + 1 + LAT;
      end
      m_sx  = ok ? x : 0;
      m_sy  = ok ? y : 0;
      m_cnt = ok ? 1 : 0;
    end else if (ok) begin
      m_sx  += x;
      m_sy  += y;
      m_cnt += 1;
    end
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0);
  endtask

  task automatic burst(input int x, input int y, input int n);
    for (int i = 0; i < n; i++) drive(x, y, 1'b1, 1'b0);
  endtask

  // Wait (bounded) for every queued result, then confirm the held outputs.
  task automatic drain(input string tag);
    for (int i = 0; i < 3 * LAT && sb.size() != 0; i++) idle(1);
    check({tag, "_drained"}, 64'(sb.size()), 0);
    sb.delete();
    idle(LAT + 4);
    check({tag, "_x_hold"}, bus.x_out, last_x);
    check({tag, "_y_hold"}, bus.y_out, last_y);
  endtask

  always @(negedge clk_in) begin
    if (rst_in_n) begin
      if (bus.valid_out) begin
        check("back_to_back_valid", prev_valid, 1'b0);
        check("valid_expected", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          got_e = sb.pop_front();
          check("x_out", bus.x_out, got_e.x);
          check("y_out", bus.y_out, got_e.y);
          check("latency_cycle", cyc, got_e.cyc);
          last_x = got_e.x;
          last_y = got_e.y;
        end
      end
      prev_valid = bus.valid_out;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.x_in = '0; bus.y_in = '0; bus.valid_in = 1'b0; bus.tabulate_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_x_out", bus.x_out, 0);
    check("rst_y_out", bus.y_out, 0);
    check("rst_valid_out", bus.valid_out, 0);
    rst_in_n = 1'b1;
    idle(2);

    // 15 pixels after reset: below threshold, outputs stay 0.
    burst(640, 360, 15); drive(0, 0, 1'b0, 1'b1);
    drain("below_min_reset");

    // 16 pixels at (640,360).
    burst(640, 360, 16); drive(0, 0, 1'b0, 1'b1);
    drain("single_point");

    // 15 pixels again: prior (640,360) must be held.
    burst(10, 10, 15); drive(0, 0, 1'b0, 1'b1);
    drain("below_min_held");

    // x = 0..31 on y = 10 -> floor(15.5) = 15.
    for (int x = 0; x < 32; x++) drive(x, 10, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b1);
    drain("floor_row");

    // Out-of-range pixels ignored.
    burst(100, 100, 8);
    drive(1280, 100, 1'b1, 1'b0);
    drive(100, 720, 1'b1, 1'b0);
    drive(2047, 1023, 1'b1, 1'b0);
    burst(100, 100, 8);
    drive(0, 0, 1'b0, 1'b1);
    drain("out_of_range");

    // Two full-width rows at the bottom edge -> (639, 718).
    for (int y = 718; y < 720; y++)
      for (int x = 0; x < H_ACTIVE; x++) drive(x, y, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b1);
    drain("wide_rows");

    // Max corner, with a pixel on the tabulate cycle seeding the next frame (15 + 1 = 16).
    burst(1279, 719, 16);
    drive(1000, 500, 1'b1, 1'b1);
    burst(1000, 500, 15);
    idle(LAT + 2);
    drive(0, 0, 1'b0, 1'b1);
    drain("tab_pixel_carry");

    // Tabulate during DIVIDE drops that frame; running division still publishes.
    burst(10, 20, 16); drive(0, 0, 1'b0, 1'b1);
    burst(30, 40, 16); drive(0, 0, 1'b0, 1'b1);
    idle(LAT);
    drive(0, 0, 1'b0, 1'b1);
    drain("drop_in_divide");

    // Reset at divide cycle 10 discards the result.
    burst(200, 300, 16); drive(0, 0, 1'b0, 1'b1);
    idle(10);
    rst_in_n = 1'b0;
    sb.delete();
    m_sx = 0; m_sy = 0; m_cnt = 0; busy_end = -1;
    last_x = 0; last_y = 0;
    #1;
    check("midrst_x_out", bus.x_out, 0);
    check("midrst_y_out", bus.y_out, 0);
    check("midrst_valid_out", bus.valid_out, 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in_n = 1'b1;
    idle(2);
    drain("after_reset_quiet");

    burst(5, 7, 16); drive(0, 0, 1'b0, 1'b1);
    drain("post_reset_frame");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
